// File: rtl/acc_job_scheduler.sv
// Job sequencer in front of an accelerator: queues (U,V) jobs, launches them, forwards results.
// Optional watchdog on the done wait is enabled with ACC_TIMEOUT_EN.
module acc_job_scheduler #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  input  logic [1:0]        job_u,
  input  logic [4:0]        job_v,
  output logic              job_ready,
  output logic              acc_start,
  output logic [1:0]        acc_U,
  output logic [4:0]        acc_V,
  input  logic              acc_done,
  input  logic              acc_wr_req,
  input  logic [20:0]       acc_wr_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [20:0]       mem_wdata,
  output logic              busy,
  output logic [7:0]        jobs_done,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [PW:0] ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_POP
  } state_e;

  state_e state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;

  logic [6:0]    fifo_q [DEPTH];
  logic [PW:0]   wr_q, rd_q, cnt;
  logic [PW-1:0] rd_nx;
  logic          empty, push, pop;
  logic          load, load_nx, inc;

  logic [1:0]        u_q;
  logic [4:0]        v_q;
  logic [7:0]        jd_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q, ptr_q;
  logic [20:0]       wdata_q;
  logic              fwd;

  assign cnt       = wr_q - rd_q;
  assign empty     = (cnt == '0);
  assign job_ready = ~cnt[PW];
  assign push      = job_valid & job_ready;
  assign rd_nx     = rd_q[PW-1:0] + 1'b1;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q[PW-1:0]] <= {job_u, job_v};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

`ifdef ACC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog_q, wdog_d;
  logic          to_q, to_d, err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
      to_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      to_q   <= to_d;
      err_q  <= err_d;
    end
  end
`else
  logic to_q, err_q;
  logic unused_timeout;
  assign to_q           = 1'b0;
  assign err_q          = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    pop     = 1'b0;
    inc     = 1'b0;
    load    = 1'b0;
    load_nx = 1'b0;
`ifdef ACC_TIMEOUT_EN
    wdog_d  = '0;
    to_d    = to_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_LAUNCH;
          scnt_d  = '0;
          load    = 1'b1;
        end
      end
      S_LAUNCH: begin
        if (scnt_q == SW'(START_CYC - 1)) state_d = S_WAIT;
        else scnt_d = scnt_q + 1'b1;
      end
      S_WAIT: begin
`ifdef ACC_TIMEOUT_EN
        wdog_d = wdog_q + 1'b1;
        if (acc_done) begin
          state_d = S_POP;
        end else if (wdog_q == TW'(TIMEOUT - 1)) begin
          state_d = S_POP;
          to_d    = 1'b1;
          err_d   = 1'b1;
        end
`else
        if (acc_done) state_d = S_POP;
`endif
      end
      S_POP: begin
        pop = 1'b1;
        inc = ~to_q;
`ifdef ACC_TIMEOUT_EN
        to_d = 1'b0;
`endif
        // Decide on the pre-pop count; a same-cycle push is seen next cycle
        if (cnt > ONE) begin
          state_d = S_LAUNCH;
          scnt_d  = '0;
          load_nx = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fwd = acc_wr_req & ((state_q == S_LAUNCH) | (state_q == S_WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
      u_q     <= '0;
      v_q     <= '0;
      jd_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      if (load) {u_q, v_q} <= fifo_q[rd_q[PW-1:0]];
      if (load_nx) {u_q, v_q} <= fifo_q[rd_nx];
      if (inc && jd_q != 8'hFF) jd_q <= jd_q + 1'b1;
      we_q <= fwd;
      if (fwd) begin
        addr_q  <= ptr_q;
        wdata_q <= acc_wr_data;
        ptr_q   <= ptr_q + 1'b1;
      end
    end
  end

  assign acc_start = (state_q == S_LAUNCH);
  assign acc_U     = u_q;
  assign acc_V     = v_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE) | ~empty;
  assign jobs_done = jd_q;
  assign err       = err_q;

endmodule

// File: tb/tb_acc_job_scheduler.sv
// Scoreboard bench for acc_job_scheduler: write beats and job launches are
// queued as issued and checked by independent monitors.
module tb_acc_job_scheduler;

  logic        clk = 0;
  logic        rst;
  logic        job_valid;
  logic [1:0]  job_u;
  logic [4:0]  job_v;
  logic        job_ready;
  logic        acc_start;
  logic [1:0]  acc_U;
  logic [4:0]  acc_V;
  logic        acc_done;
  logic        acc_wr_req;
  logic [20:0] acc_wr_data;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [20:0] mem_wdata;
  logic        busy;
  logic [7:0]  jobs_done;
  logic        err;

  acc_job_scheduler #(
    .DEPTH(4), .ADDR_W(2), .START_CYC(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_u(job_u), .job_v(job_v),
    .job_ready(job_ready),
    .acc_start(acc_start), .acc_U(acc_U), .acc_V(acc_V),
    .acc_done(acc_done), .acc_wr_req(acc_wr_req),
    .acc_wr_data(acc_wr_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .jobs_done(jobs_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  a;
    logic [20:0] d;
    int          c;
  } wr_t;

  wr_t        wq[$];
  logic [6:0] jq[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int run_len = 0;
  logic prev_st = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", int'(mem_addr), int'(e.a));
        chk("wr_data", int'(mem_wdata), int'(e.d));
        chk("wr_latency", cyc_n, e.c);
      end
    end
  end

  always @(negedge clk) begin
    if (acc_start && !prev_st) begin
      run_len = 1;
      if (jq.size() == 0) begin
        chk("unexpected_launch", 1, 0);
      end else begin
        logic [6:0] j;
        j = jq.pop_front();
        chk("launch_uv", int'({acc_U, acc_V}), int'(j));
      end
    end else if (acc_start) begin
      run_len++;
    end else if (prev_st) begin
      chk("start_len", run_len, 2);
    end
    prev_st = acc_start;
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_job(logic [1:0] u, logic [4:0] v, bit exp);
    job_valid = 1; job_u = u; job_v = v;
    if (exp) jq.push_back({u, v});
    cyc(1);
    job_valid = 0;
  endtask

  task automatic beat(logic [1:0] a, logic [20:0] d, bit dn);
    acc_wr_req = 1; acc_wr_data = d; acc_done = dn;
    wq.push_back('{a: a, d: d, c: cyc_n + 1});
    cyc(1);
    acc_wr_req = 0; acc_done = 0;
  endtask

  task automatic pulse_done();
    acc_done = 1;
    cyc(1);
    acc_done = 0;
  endtask

  initial begin
    rst = 0; job_valid = 0; job_u = 0; job_v = 0;
    acc_done = 0; acc_wr_req = 0; acc_wr_data = 0;
    cyc(2);
    chk("rst_start", acc_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1;
    cyc(1);
    chk("ready_after_rst", job_ready, 1);

    // single job, done 10 cycles into WAIT
    push_job(2'd2, 5'd5, 1);
    cyc(12);
    pulse_done();
    chk("busy_in_pop", busy, 1);
    cyc(1);
    chk("jobs_done_1", jobs_done, 1);
    chk("busy_idle_1", busy, 0);

    // write stream, last beat with done, then a dropped beat in POP
    push_job(2'd1, 5'd3, 1);
    cyc(3);
    beat(2'd0, 21'h1, 0);
    beat(2'd1, 21'h2, 0);
    beat(2'd2, 21'h1FFFFF, 1);
    acc_wr_req = 1; acc_wr_data = 21'h55;
    cyc(1);
    acc_wr_req = 0;
    cyc(2);
    chk("jobs_done_2", jobs_done, 2);

    // full FIFO
    chk("ready_j1", job_ready, 1);
    push_job(2'd0, 5'd1, 1);
    push_job(2'd1, 5'd2, 1);
    push_job(2'd2, 5'd3, 1);
    push_job(2'd3, 5'd4, 1);
    chk("ready_full", job_ready, 0);
    push_job(2'd3, 5'd31, 0);
    chk("ready_still_full", job_ready, 0);
    for (int k = 0; k < 4; k++) begin
      pulse_done();
      cyc(1);
      if (k < 3) begin
        pulse_done();
        cyc(1);
      end
    end
    chk("jobs_done_6", jobs_done, 6);
    chk("busy_idle_6", busy, 0);

    // reset mid-WAIT with two jobs queued
    push_job(2'd3, 5'd17, 1);
    push_job(2'd2, 5'd9, 0);
    cyc(3);
    rst = 0;
    cyc(1);
    chk("mrst_start", acc_start, 0);
    chk("mrst_uv", int'({acc_U, acc_V}), 0);
    chk("mrst_we", mem_we, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_wdata", mem_wdata, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_jobs", jobs_done, 0);
    chk("mrst_err", err, 0);
    rst = 1;
    cyc(2);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", job_ready, 1);

    // address wrap with ADDR_W=2
    push_job(2'd1, 5'd9, 1);
    cyc(3);
    beat(2'd0, 21'h10, 0);
    beat(2'd1, 21'h11, 0);
    beat(2'd2, 21'h12, 0);
    beat(2'd3, 21'h13, 0);
    beat(2'd0, 21'h14, 1);
    cyc(1);
    chk("jobs_done_wrap", jobs_done, 1);

`ifdef ACC_TIMEOUT_EN
    push_job(2'd2, 5'd7, 1);
    push_job(2'd1, 5'd30, 1);
    cyc(9);
    chk("err_before", err, 0);
    cyc(1);
    chk("err_set", err, 1);
    chk("jobs_to", jobs_done, 1);
    cyc(3);
    pulse_done();
    cyc(1);
    chk("jobs_after_to", jobs_done, 2);
    chk("err_sticky", err, 1);
`else
    chk("err_tied", err, 0);
`endif

    cyc(3);
    chk("wq_empty", wq.size(), 0);
    chk("jq_empty", jq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
